// File: rtl/fifo_pacer_rx_pkg.sv
// Shared defaults and pacing FSM encoding for the paced FIFO receiver.
package fifo_pacer_rx_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_pacer_rx_sync_fifo_ram.sv
// Synchronous FIFO: 2**AW x DW dual-port RAM with fill-level tracking and a
// registered read port (data appears the cycle after rd).
module sync_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] q,
    output logic [AW:0]   usedw,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (usedw == DEPTH);
    assign empty = (usedw == '0);
    assign rd_ok = rd & ~empty;
    // A read in the same cycle frees a slot, so a write at full still lands.
    assign wr_ok = wr & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            q      <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                q      <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pacer_rx.sv
// Paced FIFO receiver: buffers a bursty byte stream and re-emits one byte
// every cfg_gap+1 cycles; sticky ovf_err flags bytes dropped at full.
module fifo_pacer_rx
    import fifo_pacer_rx_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cfg_gap,
    input  logic          clr_err,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic [AW:0]   usedw,
    output logic          ovf_err
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       rd;
    logic       full;
    logic       empty;
    logic       drop;

    sync_fifo_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (din_vld),
        .wdata (din),
        .rd    (rd),
        .q     (dout),
        .usedw (usedw),
        .full  (full),
        .empty (empty)
    );

    assign drop = din_vld & full & ~rd;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rd       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    rd     = 1'b1;
                    cnt_nx = cfg_gap;
                    if (cfg_gap != 8'd0) begin
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                cnt_nx = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            dout_vld <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            dout_vld <= rd;
            // A drop in the same cycle as clr_err keeps the flag set.
            if (drop) begin
                ovf_err <= 1'b1;
            end else if (clr_err) begin
                ovf_err <= 1'b0;
            end
        end
    end

endmodule
